// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage; owns the PC, issues single-outstanding
//            fetches and drives the IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter int                 ADDR_W    = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [2:0]         HOLD_IF   = 3'd1,
  parameter logic [2:0]         HOLD_ID   = 3'd2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         hold_code,
  input  logic               jmp_flag_i,
  input  logic [ADDR_W-1:0]  jmp_addr_i,
  output logic               instr_req_o,
  output logic [ADDR_W-1:0]  instr_addr_o,
  input  logic               instr_rvalid_i,
  input  logic [INSTR_W-1:0] instr_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  addr_instr_o,
  output logic               instr_valid_o
);

  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_WAIT      = 2'd1,
    ST_HOLD_DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               kill_q, kill_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;

  logic               hold_if, hold_id, jump, req;
  logic [ADDR_W-1:0]  req_addr, pc_plus4;

  assign hold_if  = (hold_code >= HOLD_IF);
  assign hold_id  = (hold_code >= HOLD_ID);
  // Decode re-presents a jump after an ID hold, so it is only sampled here.
  assign jump     = jmp_flag_i && !hold_id;
  assign pc_plus4 = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    req          = 1'b0;
    req_addr     = pc_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    valid_d      = valid_q;

    if (!hold_id) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    if (jump) begin
      pc_d         = jmp_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
      state_d      = ST_ISSUE;
      kill_d       = (state_q == ST_WAIT) && !instr_rvalid_i;
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          // A killed response is still in flight; wait for it before reissuing.
          if (kill_q) begin
            if (instr_rvalid_i) kill_d = 1'b0;
          end else if (!hold_if) begin
            req     = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (instr_rvalid_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ST_ISSUE;
            end else if (!hold_id) begin
              instr_d = instr_rdata_i;
              addr_d  = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
              if (!hold_if) begin
                req      = 1'b1;
                req_addr = pc_plus4;
              end else begin
                state_d = ST_ISSUE;
              end
            end else begin
              skid_instr_d = instr_rdata_i;
              skid_pc_d    = pc_q;
              state_d      = ST_HOLD_DATA;
            end
          end
        end
        ST_HOLD_DATA: begin
          if (!hold_id) begin
            instr_d = skid_instr_q;
            addr_d  = skid_pc_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_ISSUE;
          end
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      addr_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
    end
  end

  assign instr_req_o   = req && rst_n;
  assign instr_addr_o  = req_addr;
  assign instr_o       = instr_q;
  assign addr_instr_o  = addr_q;
  assign instr_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Scoreboard bench for if_stage with a latency-programmable memory.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hold_code;
  logic        jmp_flag;
  logic [63:0] jmp_addr;
  logic        instr_req;
  logic [63:0] instr_addr;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic [31:0] instr_out;
  logic [63:0] addr_instr;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  logic [63:0] exp_req[$];
  logic [95:0] exp_ifid[$];

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hold_code      (hold_code),
    .jmp_flag_i     (jmp_flag),
    .jmp_addr_i     (jmp_addr),
    .instr_req_o    (instr_req),
    .instr_addr_o   (instr_addr),
    .instr_rvalid_i (instr_rvalid),
    .instr_rdata_i  (instr_rdata),
    .instr_o        (instr_out),
    .addr_instr_o   (addr_instr),
    .instr_valid_o  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_bubble(input string name, input logic [63:0] exp_addr);
    chk({name, "_valid"}, {95'd0, instr_valid}, 96'd0);
    chk({name, "_instr"}, {64'd0, instr_out}, {64'd0, 32'h0000_0013});
    chk({name, "_addr"}, {32'd0, addr_instr}, {32'd0, exp_addr});
  endtask

  // Memory: answers each request after lat cycles with the low address word.
  initial begin
    logic        busy;
    int          cnt;
    logic [63:0] maddr;
    busy = 1'b0;
    cnt = 0;
    maddr = '0;
    instr_rvalid = 1'b0;
    instr_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) busy = 1'b0;
      else if (instr_req) begin
        busy = 1'b1;
        cnt = lat;
        maddr = instr_addr;
      end
      @(posedge clk);
      #1;
      instr_rvalid = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          instr_rvalid = 1'b1;
          instr_rdata = maddr[31:0];
          busy = 1'b0;
        end
      end
    end
  end

  // Monitor: IF/ID loads only when the previous cycle's hold was below HOLD_ID.
  initial begin
    logic [2:0] prev_hold;
    prev_hold = 3'd0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_req) begin
        if (exp_req.size() == 0) chk("unexpected_req", {32'd0, instr_addr}, 96'd0);
        else chk("req_addr", {32'd0, instr_addr}, {32'd0, exp_req.pop_front()});
      end
      if (rst_n && instr_valid && prev_hold < 3'd2) begin
        if (exp_ifid.size() == 0) chk("unexpected_ifid", {instr_out, addr_instr}, 96'd0);
        else chk("ifid", {instr_out, addr_instr}, exp_ifid.pop_front());
      end
      prev_hold = hold_code;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    hold_code = 3'd0;
    jmp_flag = 1'b0;
    jmp_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {95'd0, instr_req}, 96'd0);
    chk_bubble("rst", 64'd0);

    // Back-to-back stream, then hold=1 drains it into bubbles
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(64'h8000_0000 + 64'(4 * i));
      exp_ifid.push_back({32'h8000_0000 + 32'(4 * i), 64'h8000_0000 + 64'(4 * i)});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;                       // cycle 0
    tick(4); hold_code = 3'd1;          // cycle 4
    tick(3); @(negedge clk);
    chk_bubble("hold1_drain", 64'h8000_000C);

    // Response captured in skid buffer during hold=2
    exp_req.push_back(64'h8000_0010);
    exp_ifid.push_back({32'h8000_0010, 64'h8000_0010});
    tick(1); hold_code = 3'd0;          // cycle 8
    tick(1); hold_code = 3'd2;          // cycle 9
    tick(2); @(negedge clk);            // cycle 11
    chk_bubble("hold2_frozen", 64'h8000_000C);
    tick(1); hold_code = 3'd0;          // cycle 12
    tick(1); hold_code = 3'd1;          // cycle 13

    // Jump while WAITing on a 3-cycle memory
    exp_req.push_back(64'h8000_0014);
    exp_req.push_back(64'h8000_0100);
    tick(1); lat = 3; hold_code = 3'd0; // cycle 14
    tick(1); jmp_flag = 1'b1; jmp_addr = 64'h8000_0103;
    tick(1); jmp_flag = 1'b0;           // cycle 16
    @(negedge clk);
    chk_bubble("jump_wait", 64'h8000_0010);

    // Jump coincident with rvalid, then jump under hold=2, then taken
    exp_req.push_back(64'h8000_0200);
    exp_req.push_back(64'h8000_0300);
    exp_ifid.push_back({32'h8000_0200, 64'h8000_0200});
    exp_ifid.push_back({32'h8000_0300, 64'h8000_0300});
    tick(5); lat = 1; jmp_flag = 1'b1; jmp_addr = 64'h8000_0200;  // cycle 21
    tick(1); jmp_flag = 1'b0;           // cycle 22
    @(negedge clk);
    chk_bubble("jump_rvalid_drop", 64'h8000_0010);
    tick(1); hold_code = 3'd2; jmp_flag = 1'b1; jmp_addr = 64'h8000_0300;
    tick(1); hold_code = 3'd0; jmp_flag = 1'b0;                   // cycle 24
    tick(1); jmp_flag = 1'b1;           // cycle 25
    tick(1); jmp_flag = 1'b0;           // cycle 26
    @(negedge clk);
    chk_bubble("jump_taken", 64'h8000_0200);
    tick(1); hold_code = 3'd1;          // cycle 27

    // Reset mid-WAIT
    exp_req.push_back(64'h8000_0304);
    exp_req.push_back(64'h8000_0000);
    exp_ifid.push_back({32'h8000_0000, 64'h8000_0000});
    tick(1); lat = 3; hold_code = 3'd0; // cycle 28
    tick(1); rst_n = 1'b0;              // cycle 29
    #1;
    chk("midrst_req", {95'd0, instr_req}, 96'd0);
    chk_bubble("midrst", 64'd0);
    tick(1); rst_n = 1'b1;              // cycle 30
    tick(3); hold_code = 3'd1;          // cycle 33
    tick(2); @(negedge clk);
    chk_bubble("final", 64'h8000_0000);
    chk("req_left", {64'd0, 32'(exp_req.size())}, 96'd0);
    chk("ifid_left", {64'd0, 32'(exp_ifid.size())}, 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
